// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler control unit: opcodes, ALU select codes,
// B-source codes, FSM state encodings and the decoded control payload.
package nibbler_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned BSRC_W  = 2;
    localparam int unsigned STATE_W = 2;

    // Opcodes (IR[7:4])
    localparam logic [OP_W-1:0] OP_JC    = 4'h0;
    localparam logic [OP_W-1:0] OP_JNC   = 4'h1;
    localparam logic [OP_W-1:0] OP_CMPI  = 4'h2;
    localparam logic [OP_W-1:0] OP_CMPM  = 4'h3;
    localparam logic [OP_W-1:0] OP_LIT   = 4'h4;
    localparam logic [OP_W-1:0] OP_IN    = 4'h5;
    localparam logic [OP_W-1:0] OP_LD    = 4'h6;
    localparam logic [OP_W-1:0] OP_ST    = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ    = 4'h8;
    localparam logic [OP_W-1:0] OP_JNZ   = 4'h9;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'hA;
    localparam logic [OP_W-1:0] OP_ADDM  = 4'hB;
    localparam logic [OP_W-1:0] OP_JMP   = 4'hC;
    localparam logic [OP_W-1:0] OP_OUT   = 4'hD;
    localparam logic [OP_W-1:0] OP_NANDI = 4'hE;
    localparam logic [OP_W-1:0] OP_NANDM = 4'hF;

    // ALU select codes
    localparam logic [SEL_W-1:0] ALU_PASSA = 3'd0;
    localparam logic [SEL_W-1:0] ALU_CMP   = 3'd1;
    localparam logic [SEL_W-1:0] ALU_PASSB = 3'd2;
    localparam logic [SEL_W-1:0] ALU_ADD   = 3'd3;
    localparam logic [SEL_W-1:0] ALU_NAND  = 3'd4;

    // B-operand mux codes
    localparam logic [BSRC_W-1:0] BSRC_OPERAND = 2'd0;
    localparam logic [BSRC_W-1:0] BSRC_RAM     = 2'd1;
    localparam logic [BSRC_W-1:0] BSRC_PORT    = 2'd2;

    // FSM states
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd0;
    localparam logic [STATE_W-1:0] ST_ADDR  = 2'd1;
    localparam logic [STATE_W-1:0] ST_EXEC  = 2'd2;

    // Control payload driven towards the ALU / register file
    typedef struct packed {
        logic [SEL_W-1:0]  alu_sel;
        logic [BSRC_W-1:0] b_src;
        logic              load_acc;
        logic              load_flags;
        logic              ram_we;
        logic              out_load;
    } ctrl_t;

    // Opcodes that carry an addr_lo second byte
    function automatic logic op_is_two_byte(input logic [OP_W-1:0] op);
        case (op)
            OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST,
            OP_JZ, OP_JNZ, OP_ADDM, OP_JMP, OP_NANDM: op_is_two_byte = 1'b1;
            default:                                  op_is_two_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Combinational (state, opcode) -> control decode for the Nibbler.
// Strobes are only produced in EXEC; instruction-length and jump class are
// reported for any state so the sequencer can use them while fetching.
module nibbler_decode
    import nibbler_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [OP_W-1:0]    opcode_i,
    output ctrl_t              ctrl_c,
    output logic               is_two_byte_c,
    output logic               is_jump_c
);

    // Moore decode of the control strobes plus instruction class
    always_comb begin
        ctrl_c        = '0;
        is_two_byte_c = op_is_two_byte(opcode_i);
        is_jump_c     = 1'b0;

        case (opcode_i)
            OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: is_jump_c = 1'b1;
            default:                              is_jump_c = 1'b0;
        endcase

        if (state_i == ST_EXEC) begin
            case (opcode_i)
                OP_CMPI: begin
                    ctrl_c.alu_sel    = ALU_CMP;
                    ctrl_c.b_src      = BSRC_OPERAND;
                    ctrl_c.load_flags = 1'b1;
                end
                OP_CMPM: begin
                    ctrl_c.alu_sel    = ALU_CMP;
                    ctrl_c.b_src      = BSRC_RAM;
                    ctrl_c.load_flags = 1'b1;
                end
                OP_LIT: begin
                    ctrl_c.alu_sel  = ALU_PASSB;
                    ctrl_c.b_src    = BSRC_OPERAND;
                    ctrl_c.load_acc = 1'b1;
                end
                OP_IN: begin
                    ctrl_c.alu_sel  = ALU_PASSB;
                    ctrl_c.b_src    = BSRC_PORT;
                    ctrl_c.load_acc = 1'b1;
                end
                OP_LD: begin
                    ctrl_c.alu_sel  = ALU_PASSB;
                    ctrl_c.b_src    = BSRC_RAM;
                    ctrl_c.load_acc = 1'b1;
                end
                OP_ST: begin
                    ctrl_c.ram_we = 1'b1;
                end
                OP_ADDI, OP_ADDM: begin
                    ctrl_c.alu_sel    = ALU_ADD;
                    ctrl_c.b_src      = (opcode_i == OP_ADDM) ? BSRC_RAM : BSRC_OPERAND;
                    ctrl_c.load_acc   = 1'b1;
                    ctrl_c.load_flags = 1'b1;
                end
                OP_NANDI, OP_NANDM: begin
                    ctrl_c.alu_sel    = ALU_NAND;
                    ctrl_c.b_src      = (opcode_i == OP_NANDM) ? BSRC_RAM : BSRC_OPERAND;
                    ctrl_c.load_acc   = 1'b1;
                    ctrl_c.load_flags = 1'b1;
                end
                OP_OUT: begin
                    ctrl_c.out_load = 1'b1;
                end
                default: begin
                    ctrl_c = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/nibbler_control.sv
// Nibbler fetch/decode/sequencing control unit. Holds PC, IR, addr_lo and the
// FETCH/ADDR/EXEC state machine; drives ALU select, B source and strobes.
// Optional build macro NIBBLER_STEP_EN adds a 'step' input gating FETCH.
module nibbler_control
    import nibbler_pkg::*;
#(
    parameter int unsigned     PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
`ifdef NIBBLER_STEP_EN
    input  logic               step,
`endif
    input  logic [7:0]         prog_byte,
    input  logic               c_flag,
    input  logic               z_flag,
    output logic [PC_W-1:0]    pc,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         operand,
    output logic [SEL_W-1:0]   alu_sel,
    output logic [BSRC_W-1:0]  b_src,
    output logic [11:0]        ram_addr,
    output logic               load_acc,
    output logic               load_flags,
    output logic               ram_we,
    output logic               out_load
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [7:0]         ir_q, ir_d;
    logic [7:0]         addr_lo_q, addr_lo_d;
    logic [STATE_W-1:0] state_q, state_d;

    logic [STATE_W-1:0] dec_state_c;
    logic [OP_W-1:0]    dec_op_c;
    ctrl_t              ctrl_c;
    logic               is_two_byte_c;
    logic               is_jump_c;
    logic               jump_taken_c;
    logic               advance_c;

`ifdef NIBBLER_STEP_EN
    assign advance_c = step;
`else
    assign advance_c = 1'b1;
`endif

    // While fetching, classify the incoming byte; otherwise decode the held IR.
    // Reset forces the decoder to an idle state so no strobe leaks out.
    assign dec_op_c    = (state_q == ST_FETCH) ? prog_byte[7:4] : ir_q[7:4];
    assign dec_state_c = reset ? ST_FETCH : state_q;

    nibbler_decode u_decode (
        .state_i       (dec_state_c),
        .opcode_i      (dec_op_c),
        .ctrl_c        (ctrl_c),
        .is_two_byte_c (is_two_byte_c),
        .is_jump_c     (is_jump_c)
    );

    // Resolve the branch condition from the registered flags
    always_comb begin
        jump_taken_c = 1'b0;
        case (ir_q[7:4])
            OP_JC:   jump_taken_c = c_flag;
            OP_JNC:  jump_taken_c = !c_flag;
            OP_JZ:   jump_taken_c = z_flag;
            OP_JNZ:  jump_taken_c = !z_flag;
            OP_JMP:  jump_taken_c = 1'b1;
            default: jump_taken_c = 1'b0;
        endcase
    end

    // Next-state logic for the sequencer, PC, IR and addr_lo
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_lo_d = addr_lo_q;

        case (state_q)
            ST_FETCH: begin
                if (advance_c) begin
                    ir_d    = prog_byte;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = is_two_byte_c ? ST_ADDR : ST_EXEC;
                end
            end
            ST_ADDR: begin
                addr_lo_d = prog_byte;
                pc_d      = pc_q + PC_W'(1);
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_jump_c && jump_taken_c) begin
                    pc_d = PC_W'({ir_q[3:0], addr_lo_q});
                end
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            addr_lo_q <= 8'h00;
            state_q   <= ST_FETCH;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_lo_q <= addr_lo_d;
            state_q   <= state_d;
        end
    end

    assign pc         = pc_q;
    assign state      = state_q;
    assign operand    = ir_q[3:0];
    assign ram_addr   = {ir_q[3:0], addr_lo_q};
    assign alu_sel    = ctrl_c.alu_sel;
    assign b_src      = ctrl_c.b_src;
    assign load_acc   = ctrl_c.load_acc;
    assign load_flags = ctrl_c.load_flags;
    assign ram_we     = ctrl_c.ram_we;
    assign out_load   = ctrl_c.out_load;

endmodule

// File: tb/tb_nibbler_control.sv
// Directed self-checking bench for nibbler_control with a behavioural ROM.
module tb_nibbler_control;

    logic        clock;
    logic        reset;
    logic        step;
    logic [7:0]  prog_byte;
    logic        c_flag;
    logic        z_flag;
    logic [11:0] pc;
    logic [1:0]  state;
    logic [3:0]  operand;
    logic [2:0]  alu_sel;
    logic [1:0]  b_src;
    logic [11:0] ram_addr;
    logic        load_acc;
    logic        load_flags;
    logic        ram_we;
    logic        out_load;

    logic [7:0]  rom [0:4095];
    logic [3:0]  strobes;

    int checks   = 0;
    int failures = 0;

    assign prog_byte = rom[pc];
    assign strobes   = {load_acc, load_flags, ram_we, out_load};

    nibbler_control #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef NIBBLER_STEP_EN
        .step       (step),
`endif
        .prog_byte  (prog_byte),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .pc         (pc),
        .state      (state),
        .operand    (operand),
        .alu_sel    (alu_sel),
        .b_src      (b_src),
        .ram_addr   (ram_addr),
        .load_acc   (load_acc),
        .load_flags (load_flags),
        .ram_we     (ram_we),
        .out_load   (out_load)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One-byte ops: {byte, alu_sel, b_src, strobes {acc,flags,we,out}}
    logic [7:0] ob_byte [6] = '{8'h47, 8'h50, 8'h29, 8'hA6, 8'hE3, 8'hD5};
    logic [2:0] ob_sel  [6] = '{3'd2,  3'd2,  3'd1,  3'd3,  3'd4,  3'd0};
    logic [1:0] ob_bsrc [6] = '{2'd0,  2'd2,  2'd0,  2'd0,  2'd0,  2'd0};
    logic [3:0] ob_strb [6] = '{4'b1000, 4'b1000, 4'b0100, 4'b1100, 4'b1100, 4'b0001};

    // Two-byte memory ops: {byte0, byte1, alu_sel, b_src, strobes, ram_addr}
    logic [7:0]  tb_b0   [5] = '{8'h7A, 8'h6B, 8'hF1, 8'h3C, 8'hB9};
    logic [7:0]  tb_b1   [5] = '{8'h0F, 8'h21, 8'h02, 8'hD4, 8'h80};
    logic [2:0]  tb_sel  [5] = '{3'd0,  3'd2,  3'd4,  3'd1,  3'd3};
    logic [1:0]  tb_bsrc [5] = '{2'd0,  2'd1,  2'd1,  2'd1,  2'd1};
    logic [3:0]  tb_strb [5] = '{4'b0010, 4'b1000, 4'b1100, 4'b0100, 4'b1100};
    logic [11:0] tb_addr [5] = '{12'hA0F, 12'hB21, 12'h102, 12'hCD4, 12'h980};

    // Jumps: {byte0, byte1, c_flag, z_flag, pc after EXEC}
    logic [7:0]  jp_b0  [8] = '{8'hC1, 8'h80, 8'h80, 8'h01, 8'h01, 8'h12, 8'h9A, 8'h9A};
    logic [7:0]  jp_b1  [8] = '{8'h23, 8'h50, 8'h50, 8'h34, 8'h34, 8'h34, 8'hBC, 8'hBC};
    logic        jp_c   [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    logic        jp_z   [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [11:0] jp_pc  [8] = '{12'h123, 12'h002, 12'h050, 12'h134, 12'h002, 12'h002, 12'hABC, 12'h002};

    initial begin
        reset  = 1'b1;
        step   = 1'b1;
        c_flag = 1'b0;
        z_flag = 1'b0;
        clear_rom();

        // Reset state, sampled while reset is still high
        rom[0] = 8'h47;
        tick();
        tick();
        chk("rst_pc", 16'(pc), 16'h000);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_strobes", 16'(strobes), 16'h0);
        chk("rst_sel", 16'(alu_sel), 16'd0);
        chk("rst_bsrc", 16'(b_src), 16'd0);
        reset = 1'b0;

        // LIT 7: EXEC in cycle 2
        tick();
        chk("lit_state", 16'(state), 16'd2);
        chk("lit_sel", 16'(alu_sel), 16'd2);
        chk("lit_bsrc", 16'(b_src), 16'd0);
        chk("lit_operand", 16'(operand), 16'd7);
        chk("lit_strobes", 16'(strobes), 16'b1000);
        chk("lit_pc", 16'(pc), 16'h001);
        tick();
        chk("lit_after_state", 16'(state), 16'd0);
        chk("lit_after_strobes", 16'(strobes), 16'h0);

        // One-byte instruction table
        for (int i = 0; i < 6; i++) begin
            clear_rom();
            rom[0] = ob_byte[i];
            do_reset();
            chk($sformatf("ob%0d_fetch_strobes", i), 16'(strobes), 16'h0);
            tick();
            chk($sformatf("ob%0d_state", i), 16'(state), 16'd2);
            chk($sformatf("ob%0d_sel", i), 16'(alu_sel), 16'(ob_sel[i]));
            chk($sformatf("ob%0d_bsrc", i), 16'(b_src), 16'(ob_bsrc[i]));
            chk($sformatf("ob%0d_strobes", i), 16'(strobes), 16'(ob_strb[i]));
            tick();
            chk($sformatf("ob%0d_pc", i), 16'(pc), 16'h001);
            chk($sformatf("ob%0d_idle", i), 16'(strobes), 16'h0);
        end

        // Two-byte memory instruction table
        for (int i = 0; i < 5; i++) begin
            clear_rom();
            rom[0] = tb_b0[i];
            rom[1] = tb_b1[i];
            do_reset();
            tick();
            chk($sformatf("tb%0d_addr_state", i), 16'(state), 16'd1);
            chk($sformatf("tb%0d_addr_strobes", i), 16'(strobes), 16'h0);
            tick();
            chk($sformatf("tb%0d_state", i), 16'(state), 16'd2);
            chk($sformatf("tb%0d_sel", i), 16'(alu_sel), 16'(tb_sel[i]));
            chk($sformatf("tb%0d_bsrc", i), 16'(b_src), 16'(tb_bsrc[i]));
            chk($sformatf("tb%0d_strobes", i), 16'(strobes), 16'(tb_strb[i]));
            chk($sformatf("tb%0d_ram_addr", i), 16'(ram_addr), 16'(tb_addr[i]));
            chk($sformatf("tb%0d_pc", i), 16'(pc), 16'h002);
        end

        // Jump table: conditions evaluated against flags held during EXEC
        for (int i = 0; i < 8; i++) begin
            clear_rom();
            rom[0] = jp_b0[i];
            rom[1] = jp_b1[i];
            c_flag = jp_c[i];
            z_flag = jp_z[i];
            do_reset();
            tick();
            chk($sformatf("jp%0d_addr_state", i), 16'(state), 16'd1);
            tick();
            chk($sformatf("jp%0d_exec_strobes", i), 16'(strobes), 16'h0);
            chk($sformatf("jp%0d_exec_sel", i), 16'(alu_sel), 16'd0);
            chk($sformatf("jp%0d_exec_pc", i), 16'(pc), 16'h002);
            tick();
            chk($sformatf("jp%0d_pc", i), 16'(pc), 16'(jp_pc[i]));
            chk($sformatf("jp%0d_state", i), 16'(state), 16'd0);
        end
        c_flag = 1'b0;
        z_flag = 1'b0;

        // PC wrap: LIT 4 at 0, JMP 0xFFF at 1, ADDM at 0xFFF taking addr_lo from 0x000
        clear_rom();
        rom[0]      = 8'h44;
        rom[1]      = 8'hCF;
        rom[2]      = 8'hFF;
        rom[12'hFFF] = 8'hB3;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("wrap_jmp_pc", 16'(pc), 16'hFFF);
        tick();
        chk("wrap_addr_state", 16'(state), 16'd1);
        chk("wrap_pc_rollover", 16'(pc), 16'h000);
        tick();
        chk("wrap_exec_state", 16'(state), 16'd2);
        chk("wrap_ram_addr", 16'(ram_addr), 16'h344);
        chk("wrap_sel", 16'(alu_sel), 16'd3);
        chk("wrap_bsrc", 16'(b_src), 16'd1);
        chk("wrap_strobes", 16'(strobes), 16'b1100);
        chk("wrap_pc", 16'(pc), 16'h001);

        // Reset during ADDR of CMPM aborts it
        clear_rom();
        rom[0] = 8'h3A;
        rom[1] = 8'h55;
        do_reset();
        tick();
        chk("abort_addr_state", 16'(state), 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_rst_flags", 16'(load_flags), 16'd0);
        tick();
        chk("abort_state", 16'(state), 16'd0);
        chk("abort_pc", 16'(pc), 16'h000);
        chk("abort_flags", 16'(load_flags), 16'd0);
        reset = 1'b0;
        tick();
        chk("abort_restart_state", 16'(state), 16'd1);
        chk("abort_restart_flags", 16'(load_flags), 16'd0);

        // Reset raised during EXEC masks the strobe in that same cycle
        clear_rom();
        rom[0] = 8'hA6;
        do_reset();
        tick();
        chk("exec_rst_pre_strobes", 16'(strobes), 16'b1100);
        reset = 1'b1;
        #1;
        chk("exec_rst_strobes", 16'(strobes), 16'h0);
        chk("exec_rst_sel", 16'(alu_sel), 16'd0);
        tick();
        chk("exec_rst_after_strobes", 16'(strobes), 16'h0);
        chk("exec_rst_after_pc", 16'(pc), 16'h000);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
